// File: rtl/counter_strobe_bank.sv
// Bank of independent tick counters. Each channel emits a one-cycle strobe
// after a programmable number of enabled ticks, in periodic or one-shot mode.
module counter_strobe_bank #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNELS-1:0]         enable,
  input  logic [CHANNELS-1:0]         load,
  input  logic [CHANNELS-1:0]         stop,
  input  logic [CHANNELS-1:0]         mode,
  input  logic [CHANNELS*WIDTH-1:0]   period,
  output logic [CHANNELS-1:0]         strobe,
  output logic [CHANNELS-1:0]         active,
  output logic [CHANNELS*WIDTH-1:0]   count,
  output logic [CHANNELS-1:0]         load_err,
  output logic                        strobe_any
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [CHANNELS-1:0]       strobe_q;
  logic [CHANNELS-1:0]       active_q;
  logic [CHANNELS-1:0]       load_err_q;
  logic [CHANNELS*WIDTH-1:0] count_all;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t             state_q, state_n;
    logic [WIDTH-1:0]   period_q, period_n;
    logic [WIDTH-1:0]   count_q, count_n;
    logic               mode_q, mode_n;
    logic               strobe_n, err_n;
    logic [WIDTH-1:0]   period_in;

    assign period_in = period[i*WIDTH +: WIDTH];

    // Next-state: stop beats load beats enable.
    always_comb begin
      state_n  = state_q;
      period_n = period_q;
      count_n  = count_q;
      mode_n   = mode_q;
      strobe_n = 1'b0;
      err_n    = 1'b0;
      if (stop[i]) begin
        state_n = IDLE;
        count_n = '0;
      end else if (load[i]) begin
        count_n = '0;
        if (period_in != '0) begin
          period_n = period_in;
          mode_n   = mode[i];
          state_n  = RUN;
        end else begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end else if (state_q == RUN && enable[i]) begin
        if (count_q == period_q - WIDTH'(1)) begin
          strobe_n = 1'b1;
          count_n  = '0;
          if (mode_q) state_n = DONE;
        end else begin
          count_n = count_q + WIDTH'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q       <= IDLE;
        period_q      <= '0;
        count_q       <= '0;
        mode_q        <= 1'b0;
        strobe_q[i]   <= 1'b0;
        active_q[i]   <= 1'b0;
        load_err_q[i] <= 1'b0;
      end else begin
        state_q       <= state_n;
        period_q      <= period_n;
        count_q       <= count_n;
        mode_q        <= mode_n;
        strobe_q[i]   <= strobe_n;
        active_q[i]   <= (state_n == RUN);
        load_err_q[i] <= err_n;
      end
    end

    assign count_all[i*WIDTH +: WIDTH] = count_q;
  end

  assign strobe     = strobe_q;
  assign active     = active_q;
  assign load_err   = load_err_q;
  assign count      = count_all;
  assign strobe_any = |strobe_q;

endmodule

// File: tb/tb_counter_strobe_bank.sv
// Directed self-checking bench for counter_strobe_bank (WIDTH=16, CHANNELS=4).
module tb_counter_strobe_bank;
  localparam int unsigned W = 16;
  localparam int unsigned C = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [C-1:0]   enable, load, stop, mode;
  logic [C*W-1:0] period;
  logic [C-1:0]   strobe, active, load_err;
  logic [C*W-1:0] count;
  logic           strobe_any;

  int passes = 0;
  int total  = 0;

  counter_strobe_bank #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .stop(stop),
    .mode(mode), .period(period), .strobe(strobe), .active(active),
    .count(count), .load_err(load_err), .strobe_any(strobe_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable = '0; load = '0; stop = '0; mode = '0; period = '0;
  endtask

  function automatic logic [W-1:0] cnt(input int ch);
    return count[ch*W +: W];
  endfunction

  initial begin
    logic [C-1:0] exp_s;
    logic         saw;
    int           cnt_exp[6];
    int           stb_exp[6];
    int           act_exp[6];
    int           pat[6];

    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_strobe", 64'(strobe), 64'(0));
    chk("reset_active", 64'(active), 64'(0));
    chk("reset_count", count, 64'(0));

    // Build some state, then reset asynchronously mid-cycle
    load = 4'b1111; period = {16'd3, 16'd2, 16'd1, 16'd1};
    tick();
    load = '0;
    for (int k = 0; k < 4; k++) begin
      enable = 4'($urandom); mode = 4'($urandom); period = {$urandom, $urandom};
      tick();
    end
    chk("pre_reset_active", 64'(active), 64'(4'b1111));
    #2 rst_n = 1'b0;
    #1;
    chk("areset_strobe", 64'(strobe), 64'(0));
    chk("areset_active", 64'(active), 64'(0));
    chk("areset_count", count, 64'(0));
    chk("areset_err", 64'(load_err), 64'(0));
    chk("areset_any", 64'(strobe_any), 64'(0));
    tick();
    rst_n = 1'b1;
    idle_inputs();
    enable = 4'b1111;
    tick(); tick();
    chk("post_reset_active", 64'(active), 64'(0));
    chk("post_reset_count", count, 64'(0));
    chk("post_reset_strobe", 64'(strobe), 64'(0));

    // Periodic: ch0 period 5
    idle_inputs();
    load[0] = 1'b1; period[0*W +: W] = 16'd5; enable[0] = 1'b1;
    tick();
    chk("per_load_active", 64'(active[0]), 64'(1));
    chk("per_load_count", 64'(cnt(0)), 64'(0));
    load = '0; period = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("per_strobe_%0d", k), 64'(strobe[0]), 64'((k % 5) == 0));
      chk($sformatf("per_count_%0d", k), 64'(cnt(0)), 64'(k % 5));
      chk($sformatf("per_active_%0d", k), 64'(active[0]), 64'(1));
    end
    enable = '0;
    tick();
    chk("per_hold_strobe", 64'(strobe[0]), 64'(0));
    stop[0] = 1'b1;
    tick();
    chk("per_stop_active", 64'(active[0]), 64'(0));
    chk("per_stop_count", 64'(cnt(0)), 64'(0));

    // One-shot with gaps: ch1 period 3
    idle_inputs();
    load[1] = 1'b1; mode[1] = 1'b1; period[1*W +: W] = 16'd3;
    tick();
    idle_inputs();
    pat     = '{1, 0, 1, 0, 1, 1};
    cnt_exp = '{1, 1, 2, 2, 0, 0};
    stb_exp = '{0, 0, 0, 0, 1, 0};
    act_exp = '{1, 1, 1, 1, 0, 0};
    for (int k = 0; k < 6; k++) begin
      enable[1] = 1'(pat[k]);
      tick();
      chk($sformatf("os_strobe_%0d", k), 64'(strobe[1]), 64'(stb_exp[k]));
      chk($sformatf("os_count_%0d", k), 64'(cnt(1)), 64'(cnt_exp[k]));
      chk($sformatf("os_active_%0d", k), 64'(active[1]), 64'(act_exp[k]));
    end
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      saw = saw | strobe[1];
    end
    chk("os_no_more_strobe", 64'(saw), 64'(0));
    enable = '0;

    // Priority: ch2 period 4, count 3, then load+enable, then stop+load+enable
    idle_inputs();
    load[2] = 1'b1; period[2*W +: W] = 16'd4;
    tick();
    idle_inputs();
    enable[2] = 1'b1;
    tick(); tick(); tick();
    chk("pri_count3", 64'(cnt(2)), 64'(3));
    load[2] = 1'b1; period[2*W +: W] = 16'd2;
    tick();
    chk("pri_load_strobe", 64'(strobe[2]), 64'(0));
    chk("pri_load_count", 64'(cnt(2)), 64'(0));
    chk("pri_load_active", 64'(active[2]), 64'(1));
    stop[2] = 1'b1;
    tick();
    chk("pri_stop_strobe", 64'(strobe[2]), 64'(0));
    chk("pri_stop_active", 64'(active[2]), 64'(0));
    chk("pri_stop_count", 64'(cnt(2)), 64'(0));

    // Edge periods on ch3: period 1, then period 0
    idle_inputs();
    load[3] = 1'b1; period[3*W +: W] = 16'd1;
    tick();
    idle_inputs();
    enable[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("p1_strobe_%0d", k), 64'(strobe[3]), 64'(1));
      chk($sformatf("p1_count_%0d", k), 64'(cnt(3)), 64'(0));
    end
    load[3] = 1'b1; period[3*W +: W] = 16'd0;
    tick();
    chk("p0_err", 64'(load_err[3]), 64'(1));
    chk("p0_active", 64'(active[3]), 64'(0));
    chk("p0_strobe", 64'(strobe[3]), 64'(0));
    idle_inputs();
    tick();
    chk("p0_err_one_cycle", 64'(load_err[3]), 64'(0));

    // Max period on ch0
    load[0] = 1'b1; period[0*W +: W] = 16'hFFFF;
    tick();
    idle_inputs();
    enable[0] = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 65534; k++) begin
      tick();
      saw = saw | strobe[0];
    end
    chk("pmax_no_early", 64'(saw), 64'(0));
    chk("pmax_count", 64'(cnt(0)), 64'(16'hFFFE));
    tick();
    chk("pmax_strobe", 64'(strobe[0]), 64'(1));
    chk("pmax_wrap", 64'(cnt(0)), 64'(0));

    // Independence: periods 2,3,5,7
    idle_inputs();
    stop = 4'b1111;
    tick();
    idle_inputs();
    load = 4'b1111; period = {16'd7, 16'd5, 16'd3, 16'd2};
    tick();
    idle_inputs();
    enable = 4'b1111;
    for (int k = 1; k <= 42; k++) begin
      tick();
      exp_s = {1'((k % 7) == 0), 1'((k % 5) == 0), 1'((k % 3) == 0), 1'((k % 2) == 0)};
      chk($sformatf("ind_strobe_%0d", k), 64'(strobe), 64'(exp_s));
      chk($sformatf("ind_any_%0d", k), 64'(strobe_any), 64'(|exp_s));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
